// File: rtl/video_addr_sequencer.sv
// video_addr_sequencer
// Raster address sequencer for the 3x3 line-buffer filter path. It converts
// HSync/VSync/VDE into per-pixel column/line addresses that are aligned to the
// pixel currently on the bus. It also reports line-buffer fill status and a
// border-blank flag, and it measures the geometry of each frame.
//
// Ports:
//   Clock          pixel clock, rising edge
//   Reset          asynchronous active-low reset
//   i_HSync        horizontal sync (polarity SYNC_POL), status only
//   i_VSync        vertical sync (polarity SYNC_POL)
//   i_VDE          video data enable, active-high
//   o_H_addr       column index of the current pixel
//   o_V_addr       line index within the frame
//   o_EmptyBuffer  fewer than FILL_LINES lines stored this frame
//   o_Blank        3x3 window for this pixel is incomplete
//   o_FrameStart   one-cycle pulse after the VSync active edge
//   o_LineEnd      one-cycle pulse after each VDE falling edge
//   o_LineWidth    pixel count of the last completed line
//   o_FrameLines   line count of the last completed frame
//   o_Overflow     sticky: a counter saturated in the current frame
//   o_HSyncSeen    sticky: an HSync active edge was seen since the last VSync
module video_addr_sequencer #(
    parameter int unsigned XADRSWidth = 11,
    parameter int unsigned YADRSWidth = 10,
    parameter bit          SYNC_POL   = 1'b1,
    parameter int unsigned FILL_LINES = 2
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  i_HSync,
    input  logic                  i_VSync,
    input  logic                  i_VDE,
    output logic [XADRSWidth-1:0] o_H_addr,
    output logic [YADRSWidth-1:0] o_V_addr,
    output logic                  o_EmptyBuffer,
    output logic                  o_Blank,
    output logic                  o_FrameStart,
    output logic                  o_LineEnd,
    output logic [XADRSWidth:0]   o_LineWidth,
    output logic [YADRSWidth:0]   o_FrameLines,
    output logic                  o_Overflow,
    output logic                  o_HSyncSeen
);

    // Saturation limits: all-ones in the address width, one spare bit above.
    localparam logic [XADRSWidth:0] HMax  = {1'b0, {XADRSWidth{1'b1}}};
    localparam logic [YADRSWidth:0] VMax  = {1'b0, {YADRSWidth{1'b1}}};
    localparam logic [XADRSWidth:0] HFill = FILL_LINES[XADRSWidth:0];
    localparam logic [YADRSWidth:0] VFill = FILL_LINES[YADRSWidth:0];

    logic                r_vde_d, r_vs_d, r_hs_d;
    logic [XADRSWidth:0] r_h_cnt, w_h_cnt;
    logic [YADRSWidth:0] r_v_cnt, w_v_cnt;
    logic [XADRSWidth:0] r_line_width, w_line_width;
    logic [YADRSWidth:0] r_frame_lines, w_frame_lines;
    logic                r_overflow, w_overflow;
    logic                r_hsync_seen, w_hsync_seen;
    logic                r_frame_start, w_frame_start_q;
    logic                r_line_end, w_line_end_q;

    logic w_vs, w_hs;
    logic w_frame_start, w_line_end, w_hs_edge;

    // Normalise both syncs to active-high.
    assign w_vs = i_VSync ~^ SYNC_POL;
    assign w_hs = i_HSync ~^ SYNC_POL;

    assign w_frame_start = w_vs & ~r_vs_d;
    assign w_line_end    = ~i_VDE & r_vde_d;
    assign w_hs_edge     = w_hs & ~r_hs_d;

    always_comb begin
        w_h_cnt         = r_h_cnt;
        w_v_cnt         = r_v_cnt;
        w_line_width    = r_line_width;
        w_frame_lines   = r_frame_lines;
        w_overflow      = r_overflow;
        w_hsync_seen    = r_hsync_seen;
        w_frame_start_q = 1'b0;
        w_line_end_q    = 1'b0;

        if (w_frame_start) begin
            // Frame start wins: any pixel or line end on this edge is dropped.
            w_frame_lines   = r_v_cnt;
            w_v_cnt         = '0;
            w_h_cnt         = '0;
            w_overflow      = 1'b0;
            w_hsync_seen    = 1'b0;
            w_frame_start_q = 1'b1;
        end else begin
            if (i_VDE) begin
                if (r_h_cnt == HMax) begin
                    w_overflow = 1'b1;
                end else begin
                    w_h_cnt = r_h_cnt + 1'b1;
                end
            end else begin
                w_h_cnt = '0;
            end

            if (w_line_end) begin
                w_line_width = r_h_cnt;
                w_line_end_q = 1'b1;
                if (r_v_cnt == VMax) begin
                    w_overflow = 1'b1;
                end else begin
                    w_v_cnt = r_v_cnt + 1'b1;
                end
            end

            if (w_hs_edge) begin
                w_hsync_seen = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_vde_d       <= 1'b0;
            r_vs_d        <= 1'b0;
            r_hs_d        <= 1'b0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_line_width  <= '0;
            r_frame_lines <= '0;
            r_overflow    <= 1'b0;
            r_hsync_seen  <= 1'b0;
            r_frame_start <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            r_vde_d       <= i_VDE;
            r_vs_d        <= w_vs;
            r_hs_d        <= w_hs;
            r_h_cnt       <= w_h_cnt;
            r_v_cnt       <= w_v_cnt;
            r_line_width  <= w_line_width;
            r_frame_lines <= w_frame_lines;
            r_overflow    <= w_overflow;
            r_hsync_seen  <= w_hsync_seen;
            r_frame_start <= w_frame_start_q;
            r_line_end    <= w_line_end_q;
        end
    end

    assign o_H_addr      = r_h_cnt[XADRSWidth-1:0];
    assign o_V_addr      = r_v_cnt[YADRSWidth-1:0];
    assign o_EmptyBuffer = (r_v_cnt < VFill);
    assign o_Blank       = (r_v_cnt < VFill) | (r_h_cnt < HFill);
    assign o_FrameStart  = r_frame_start;
    assign o_LineEnd     = r_line_end;
    assign o_LineWidth   = r_line_width;
    assign o_FrameLines  = r_frame_lines;
    assign o_Overflow    = r_overflow;
    assign o_HSyncSeen   = r_hsync_seen;

endmodule

// File: tb/tb_video_addr_sequencer.sv
// Testbench for video_addr_sequencer. Three instances share one raster:
// u_dut (11x10, active-high syncs), u_neg (same geometry, active-low syncs fed
// with inverted syncs) and u_sat (4-bit column counter for saturation).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge, so each sample shows the state for the pixel being driven.
module tb_video_addr_sequencer;

    logic Clock = 1'b0;
    always #5 Clock = ~Clock;

    logic Reset;
    logic vde, vs, hs;

    logic [10:0] d_h, n_h;
    logic [9:0]  d_v, n_v, s_v;
    logic [3:0]  s_h;
    logic        d_empty, d_blank, d_fs, d_le, d_ovf, d_hss;
    logic        n_empty, n_blank, n_fs, n_le, n_ovf, n_hss;
    logic        s_empty, s_blank, s_fs, s_le, s_ovf, s_hss;
    logic [11:0] d_lw, n_lw;
    logic [4:0]  s_lw;
    logic [10:0] d_fl, n_fl, s_fl;

    int unsigned n_vectors   = 0;
    int unsigned n_miscompares = 0;

    video_addr_sequencer #(
        .XADRSWidth(11), .YADRSWidth(10), .SYNC_POL(1'b1), .FILL_LINES(2)
    ) u_dut (
        .Clock(Clock), .Reset(Reset), .i_HSync(hs), .i_VSync(vs), .i_VDE(vde),
        .o_H_addr(d_h), .o_V_addr(d_v), .o_EmptyBuffer(d_empty), .o_Blank(d_blank),
        .o_FrameStart(d_fs), .o_LineEnd(d_le), .o_LineWidth(d_lw),
        .o_FrameLines(d_fl), .o_Overflow(d_ovf), .o_HSyncSeen(d_hss)
    );

    video_addr_sequencer #(
        .XADRSWidth(11), .YADRSWidth(10), .SYNC_POL(1'b0), .FILL_LINES(2)
    ) u_neg (
        .Clock(Clock), .Reset(Reset), .i_HSync(~hs), .i_VSync(~vs), .i_VDE(vde),
        .o_H_addr(n_h), .o_V_addr(n_v), .o_EmptyBuffer(n_empty), .o_Blank(n_blank),
        .o_FrameStart(n_fs), .o_LineEnd(n_le), .o_LineWidth(n_lw),
        .o_FrameLines(n_fl), .o_Overflow(n_ovf), .o_HSyncSeen(n_hss)
    );

    video_addr_sequencer #(
        .XADRSWidth(4), .YADRSWidth(10), .SYNC_POL(1'b1), .FILL_LINES(2)
    ) u_sat (
        .Clock(Clock), .Reset(Reset), .i_HSync(hs), .i_VSync(vs), .i_VDE(vde),
        .o_H_addr(s_h), .o_V_addr(s_v), .o_EmptyBuffer(s_empty), .o_Blank(s_blank),
        .o_FrameStart(s_fs), .o_LineEnd(s_le), .o_LineWidth(s_lw),
        .o_FrameLines(s_fl), .o_Overflow(s_ovf), .o_HSyncSeen(s_hss)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One pixel-clock cycle with the given inputs; returns at the falling edge.
    task automatic step(input logic v_de, input logic v_s, input logic h_s);
        @(posedge Clock);
        #1;
        vde = v_de;
        vs  = v_s;
        hs  = h_s;
        @(negedge Clock);
    endtask

    // VSync pulse held for three cycles; exp_fl < 0 skips the FrameLines check.
    task automatic do_vsync(input int exp_fl);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("fs_pulse", d_fs, 1);
        check_eq("neg_fs_pulse", n_fs, 1);
        if (exp_fl >= 0) begin
            check_eq("frame_lines", d_fl, exp_fl);
            check_eq("neg_frame_lines", n_fl, exp_fl);
        end
        check_eq("fs_v_addr", d_v, 0);
        check_eq("fs_hss_clr", d_hss, 0);
        check_eq("fs_neg_hss_clr", n_hss, 0);
        check_eq("fs_sat_ovf_clr", s_ovf, 0);
        step(1'b0, 1'b1, 1'b0);
        check_eq("fs_single", d_fs, 0);
        check_eq("neg_fs_single", n_fs, 0);
        check_eq("fs_held_v", d_v, 0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    // One active line of w pixels followed by blanking with an HSync pulse.
    task automatic do_line(input int w, input int ln);
        for (int k = 0; k < w; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check_eq("h_addr", d_h, k);
            check_eq("v_addr", d_v, ln);
            check_eq("neg_h_addr", n_h, k);
            check_eq("neg_v_addr", n_v, ln);
            check_eq("blank", d_blank, (ln < 2) || (k < 2));
            check_eq("empty", d_empty, ln < 2);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("le_pulse", d_le, 1);
        check_eq("neg_le_pulse", n_le, 1);
        check_eq("line_width", d_lw, w);
        check_eq("v_incr", d_v, ln + 1);
        check_eq("h_clr", d_h, 0);
        step(1'b0, 1'b0, 1'b1);
        check_eq("le_single", d_le, 0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("hss_set", d_hss, 1);
        check_eq("neg_hss_set", n_hss, 1);
        check_eq("no_ovf", d_ovf, 0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        Reset = 1'b0;
        vde   = 1'b0;
        vs    = 1'b0;
        hs    = 1'b0;
        repeat (2) @(negedge Clock);
        check_eq("rst_h", d_h, 0);
        check_eq("rst_empty", d_empty, 1);
        check_eq("rst_blank", d_blank, 1);
        check_eq("rst_fs", d_fs, 0);
        @(posedge Clock);
        #1;
        Reset = 1'b1;

        // 1280x720 frame: three full-width lines, the rest kept short.
        do_vsync(0);
        for (int ln = 0; ln < 720; ln++) begin
            do_line((ln < 3) ? 1280 : 6, ln);
        end
        do_vsync(720);

        // Mid-line VSync at column 500 of line 10.
        for (int ln = 0; ln < 10; ln++) begin
            do_line(8, ln);
        end
        for (int k = 0; k < 500; k++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        check_eq("mid_h_499", d_h, 499);
        step(1'b1, 1'b1, 1'b0);
        check_eq("mid_h_500", d_h, 500);
        check_eq("mid_v_10", d_v, 10);
        step(1'b0, 1'b1, 1'b0);
        check_eq("mid_v_clr", d_v, 0);
        check_eq("mid_h_clr", d_h, 0);
        check_eq("mid_frame_lines", d_fl, 10);
        check_eq("mid_no_le", d_le, 0);
        check_eq("mid_fs", d_fs, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        do_vsync(-1);

        // Saturation on the 4-bit column counter: 20 VDE cycles.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b0, 1'b0);
            check_eq("sat_h", s_h, (k <= 15) ? k : 15);
            check_eq("sat_ovf", s_ovf, k >= 16);
            check_eq("wide_h", d_h, k);
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("sat_le", s_le, 1);
        check_eq("sat_lw", s_lw, 15);
        check_eq("wide_lw", d_lw, 20);
        check_eq("wide_no_ovf", d_ovf, 0);
        step(1'b0, 1'b0, 1'b0);
        check_eq("sat_ovf_sticky", s_ovf, 1);
        do_vsync(1);

        // 16x8 frame; u_neg sees inverted syncs with the same address sequence.
        for (int ln = 0; ln < 8; ln++) begin
            do_line(16, ln);
        end
        do_vsync(8);
        do_line(16, 0);

        // Asynchronous reset mid-line, with no clock edge in between.
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        check_eq("pre_rst_h", d_h, 4);
        #2;
        Reset = 1'b0;
        #1;
        check_eq("arst_h", d_h, 0);
        check_eq("arst_v", d_v, 0);
        check_eq("arst_empty", d_empty, 1);
        check_eq("arst_blank", d_blank, 1);
        check_eq("arst_fs", d_fs, 0);
        check_eq("arst_le", d_le, 0);
        check_eq("arst_lw", d_lw, 0);
        check_eq("arst_fl", d_fl, 0);
        check_eq("arst_ovf", d_ovf, 0);
        check_eq("arst_hss", d_hss, 0);
        check_eq("arst_neg_hss", n_hss, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
